// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Data-side memory stage controller. Sits between the datapath's DM_* port
//   and a multi-cycle backing RAM. It holds a direct-mapped cache with one
//   64-bit word per line. The cache is write-through with no write-allocate.
//   mem_stall freezes the whole pipeline while a refill or a write-through is
//   outstanding.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   reset           synchronous, active-high
//   DM_addr         byte address from the MEM stage (bits [2:0] ignored)
//   DM_writeData    store data
//   DM_readEnable   load request (level, held while stalled)
//   DM_writeEnable  store request (level, held while stalled)
//   DM_readData     load data to the MEM/WB register (combinational on hit)
//   mem_stall       pipeline freeze (combinational)
//   bm_req          backing-memory request (registered)
//   bm_we           1 = write, 0 = read, valid with bm_req
//   bm_addr         word-aligned backing-memory address
//   bm_wdata        backing-memory write data
//   bm_ack          one-cycle completion pulse from backing memory
//   bm_rdata        backing-memory read data, valid with bm_ack on reads
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int N     = 64,
    parameter int IDX_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_readEnable,
    input  logic         DM_writeEnable,
    output logic [N-1:0] DM_readData,
    output logic         mem_stall,
    output logic         bm_req,
    output logic         bm_we,
    output logic [N-1:0] bm_addr,
    output logic [N-1:0] bm_wdata,
    input  logic         bm_ack,
    input  logic [N-1:0] bm_rdata
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = N - IDX_W - 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_WTHRU  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag_arr  [LINES];
    logic [N-1:0]       r_data_arr [LINES];
    logic               r_bm_req;
    logic               r_bm_we;
    logic [N-1:0]       r_bm_addr;
    logic [N-1:0]       r_bm_wdata;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [IDX_W-1:0]   w_lat_idx;
    logic [TAG_W-1:0]   w_lat_tag;
    logic               w_lat_hit;
    logic               w_rd_req;
    logic               w_wr_req;
    logic               w_ack;
    logic [N-1:0]       w_word_addr;
    logic               w_mem_stall;
    logic [N-1:0]       w_read_data;
    logic               w_unused;

    // Address split for the live request from the MEM stage.
    assign w_idx       = DM_addr[IDX_W+2:3];
    assign w_tag       = DM_addr[N-1:IDX_W+3];
    assign w_hit       = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_word_addr = {DM_addr[N-1:3], 3'b000};

    // Array updates use the latched request address, which is guaranteed
    // stable for the whole transaction.
    assign w_lat_idx = r_bm_addr[IDX_W+2:3];
    assign w_lat_tag = r_bm_addr[N-1:IDX_W+3];
    assign w_lat_hit = r_valid[w_lat_idx] && (r_tag_arr[w_lat_idx] == w_lat_tag);

    // A store takes priority over a load when both enables are high.
    assign w_wr_req = DM_writeEnable;
    assign w_rd_req = DM_readEnable && !DM_writeEnable;

    // Acks only count while a request is actually outstanding.
    assign w_ack = r_bm_req && bm_ack;

    // Byte-offset bits never select anything in a one-word line.
    assign w_unused = &{1'b0, DM_addr[2:0]};

    // Stall and load-data decode for the current cycle.
    always_comb begin
        w_mem_stall = 1'b0;
        w_read_data = {N{1'b0}};
        if (reset) begin
            w_mem_stall = 1'b0;
            w_read_data = {N{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req) begin
                        w_mem_stall = 1'b1;
                    end else if (w_rd_req) begin
                        if (w_hit) begin
                            w_read_data = r_data_arr[w_idx];
                        end else begin
                            w_mem_stall = 1'b1;
                        end
                    end else begin
                        w_mem_stall = 1'b0;
                    end
                end
                S_REFILL: w_mem_stall = 1'b1;
                S_WTHRU:  w_mem_stall = 1'b1;
                // The store retires during this cycle.
                S_DONE:   w_mem_stall = 1'b0;
                default:  w_mem_stall = 1'b0;
            endcase
        end
    end

    // Controller FSM, valid bits and backing-memory request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_valid    <= {LINES{1'b0}};
            r_bm_req   <= 1'b0;
            r_bm_we    <= 1'b0;
            r_bm_addr  <= {N{1'b0}};
            r_bm_wdata <= {N{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req) begin
                        r_bm_req   <= 1'b1;
                        r_bm_we    <= 1'b1;
                        r_bm_addr  <= w_word_addr;
                        r_bm_wdata <= DM_writeData;
                        r_state    <= S_WTHRU;
                    end else if (w_rd_req && !w_hit) begin
                        r_bm_req  <= 1'b1;
                        r_bm_we   <= 1'b0;
                        r_bm_addr <= w_word_addr;
                        r_state   <= S_REFILL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    if (w_ack) begin
                        r_valid[w_lat_idx] <= 1'b1;
                        r_bm_req           <= 1'b0;
                        r_state            <= S_IDLE;
                    end else begin
                        r_state <= S_REFILL;
                    end
                end
                S_WTHRU: begin
                    if (w_ack) begin
                        r_bm_req <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_WTHRU;
                    end
                end
                // One retire cycle; the still-asserted store enable must not
                // launch a second write.
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_bm_req <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Tag/data storage: refill fills the line, write-through updates on hit only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_arr  <= r_tag_arr;
            r_data_arr <= r_data_arr;
        end else if ((r_state == S_REFILL) && w_ack) begin
            r_tag_arr[w_lat_idx]  <= w_lat_tag;
            r_data_arr[w_lat_idx] <= bm_rdata;
        end else if ((r_state == S_WTHRU) && w_ack && w_lat_hit) begin
            r_data_arr[w_lat_idx] <= r_bm_wdata;
        end else begin
            r_tag_arr  <= r_tag_arr;
            r_data_arr <= r_data_arr;
        end
    end

    assign mem_stall   = w_mem_stall;
    assign DM_readData = w_read_data;
    assign bm_req      = r_bm_req;
    assign bm_we       = r_bm_we;
    assign bm_addr     = r_bm_addr;
    assign bm_wdata    = r_bm_wdata;

endmodule
